// File: rtl/spiker_chunk_sequencer.sv
// spiker_chunk_sequencer: snapshots a spike frame, streams it to the core in
// flow-controlled CHUNK-bit beats and reassembles the in-order result beats.
module spiker_chunk_sequencer #(
  parameter int WIDTH           = 32,
  parameter int N_SPIKES        = 784,
  parameter int CHUNK           = 16,
  parameter int MAX_OUTSTANDING = 4,
  localparam int N_REG          = (N_SPIKES + WIDTH - 1) / WIDTH,
  localparam int DATA_WIDTH     = N_REG * WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] spikes_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  core_valid_o,
  output logic [CHUNK-1:0]      core_data_o,
  input  logic                  core_ready_i,
  input  logic                  core_res_valid_i,
  input  logic [CHUNK-1:0]      core_res_data_i
);
  localparam int N_BEATS = (N_SPIKES + CHUNK - 1) / CHUNK;
  localparam int PAD_W   = N_BEATS * CHUNK;
  localparam int CW      = $clog2(N_BEATS + 1);
  localparam int OW      = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q;
  logic [PAD_W-1:0]    frame_q;
  logic [N_SPIKES-1:0] res_q;
  logic [CW-1:0]       send_q, rx_q, send_d, sel;
  logic [OW-1:0]       out_q, out_d;
  logic                valid_q, busy_q, done_q, err_q;
  logic [CHUNK-1:0]    data_q, beat;
  logic                xfer, rx_ok, rx_bad, last_rx, next_valid;
  logic [PAD_W-1:0]    res_nx;
  int                  off;
  logic [DATA_WIDTH+PAD_W-1:0] unused_bits;

  always_comb begin
    xfer       = valid_q && core_ready_i;
    rx_ok      = core_res_valid_i && state_q == RUN &&
                 out_q != '0 && rx_q < CW'(N_BEATS);
    rx_bad     = core_res_valid_i && !rx_ok;
    last_rx    = rx_ok && rx_q == CW'(N_BEATS - 1);
    send_d     = send_q + CW'(xfer);
    out_d      = out_q + OW'(xfer) - OW'(rx_ok);
    // valid is registered, so decide it from the post-edge counters
    next_valid = send_d < CW'(N_BEATS) &&
                 out_d < OW'(MAX_OUTSTANDING);
    sel        = next_valid ? send_d : '0;
    beat       = CHUNK'(frame_q >> (int'(sel) * CHUNK));
    off        = int'(rx_q) * CHUNK;
    res_nx     = (PAD_W'(res_q) & ~(PAD_W'({CHUNK{1'b1}}) << off)) |
                 (PAD_W'(core_res_data_i) << off);
  end

  assign unused_bits = {spikes_i, res_nx};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      frame_q <= '0;
      res_q   <= '0;
      send_q  <= '0;
      rx_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (rx_bad) err_q <= 1'b1;
      unique case (state_q)
        IDLE: if (start_i) begin
          state_q <= RUN;
          frame_q <= PAD_W'(spikes_i[N_SPIKES-1:0]);
          res_q   <= '0;
          err_q   <= rx_bad;
          send_q  <= '0;
          rx_q    <= '0;
          out_q   <= '0;
          busy_q  <= 1'b1;
        end
        RUN: begin
          send_q <= send_d;
          out_q  <= out_d;
          if (rx_ok) begin
            res_q <= res_nx[N_SPIKES-1:0];
            rx_q  <= rx_q + 1'b1;
          end
          if (!valid_q || core_ready_i) begin
            valid_q <= next_valid;
            data_q  <= next_valid ? beat : '0;
          end
          if (last_rx) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign result_o     = DATA_WIDTH'(res_q);
  assign core_valid_o = valid_q;
  assign core_data_o  = data_q;
endmodule

// File: doc/spiker_chunk_sequencer.md
Name: spiker_chunk_sequencer

Overview:
Second-generation spike adapter that sits between the register-file spike words and the spiker core. It snapshots an N_SPIKES-bit spike frame on a start command. It streams the frame to the core in CHUNK-bit beats over a valid/ready handshake, with a bounded number of beats in flight. It reassembles the in-order result beats into a register-aligned result vector and reports completion. This replaces the single-shot, full-width combinational hookup with a chunked, flow-controlled, status-reporting path.

Parameters:
WIDTH, 32, register word width in bits
N_SPIKES, 784, spikes per frame
CHUNK, 16, spike bits per core beat (1..N_SPIKES)
MAX_OUTSTANDING, 4, maximum beats sent to the core and not yet returned (>=1)
Derived: N_REG = ceil(N_SPIKES/WIDTH); DATA_WIDTH = N_REG*WIDTH; N_BEATS = ceil(N_SPIKES/CHUNK)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  begin a frame; single-cycle pulse from the register file
spikes_i  in  DATA_WIDTH  concatenated spike words; word i occupies bits [(i+1)*WIDTH-1 -: WIDTH]
busy_o  out  1  frame in progress
done_o  out  1  one-cycle pulse when the last result beat is stored
err_o  out  1  sticky protocol error
result_o  out  DATA_WIDTH  registered result frame, same word layout as spikes_i
core_valid_o  out  1  beat valid toward the core
core_data_o  out  CHUNK  spike beat
core_ready_i  in  1  core accepts the beat
core_res_valid_i  in  1  result beat from the core (no backpressure)
core_res_data_i  in  CHUNK  result beat, in send order

Behaviour:
- Reset (rst_i=1 at a clock edge) forces:
  - busy_o=0, done_o=0, err_o=0, core_valid_o=0, core_data_o=0, result_o=0.
  - All counters 0, FSM in IDLE.
  - Reset mid-frame aborts the frame and drops any in-flight beats.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start_i.
  - RUN -> DONE in the cycle the N_BEATS-th result beat is stored.
  - DONE -> IDLE unconditionally after one cycle.
- On an accepted start in IDLE:
  - spikes_i[N_SPIKES-1:0] is latched into the frame buffer.
  - result_o is cleared to 0, err_o is cleared, send_cnt=rx_cnt=outstanding=0.
  - busy_o=1 from the next cycle.
- start_i in RUN or DONE is ignored. No snapshot occurs and err_o is not set.
- Send path (RUN):
  - core_valid_o=1 while send_cnt<N_BEATS and outstanding<MAX_OUTSTANDING.
  - core_data_o = frame bits [send_cnt*CHUNK +: CHUNK]. Bits at index >=N_SPIKES on the last beat are driven 0.
  - A beat transfers when core_valid_o && core_ready_i; send_cnt then increments.
  - core_valid_o and core_data_o are registered outputs. Once core_valid_o is asserted, it and core_data_o hold stable until the transfer.
  - First core_valid_o is no earlier than 1 cycle after start_i.
- Receive path (RUN):
  - On core_res_valid_i, core_res_data_i is written to result bits [rx_cnt*CHUNK +: CHUNK] and rx_cnt increments.
  - Bits with index >=N_SPIKES are discarded.
  - result_o bits [DATA_WIDTH-1:N_SPIKES] are always 0.
- outstanding counter:
  - +1 on a send transfer, -1 on a result beat.
  - Simultaneous send and receive leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
- Errors (err_o sticky, set and held):
  - core_res_valid_i while outstanding==0, in any state. The beat is dropped.
  - core_res_valid_i after rx_cnt has reached N_BEATS. The beat is dropped.
- Completion:
  - done_o=1 for exactly the DONE cycle; busy_o drops to 0 in the same cycle.
  - result_o is final and stable from the DONE cycle until the next accepted start or reset.
  - A start_i in the DONE cycle is ignored; a start on the following cycle is accepted.
- Widths:
  - send_cnt and rx_cnt are $clog2(N_BEATS+1) bits.
  - outstanding is $clog2(MAX_OUTSTANDING+1) bits.
  - No counter wraps within a frame.
- Degenerate case CHUNK=N_SPIKES: N_BEATS=1. A single beat is sent and done_o follows the single result beat.
- Minimum frame latency, with core_ready_i tied 1 and a 1-cycle core echo: N_BEATS+3 cycles from start_i to done_o.

Test Plan:
- Defaults, core_ready_i=1, core echoes data 1 cycle later, spikes_i alternating 0xA5A5A5A5 words -> 49 beats sent; result_o[783:0]==spikes_i[783:0]; result_o[799:784]==0; done_o single pulse; err_o=0.
- N_SPIKES=40, CHUNK=16, spikes_i bits 39:0=0xFF_FFFF_FFFF -> 3 beats; last core_data_o=0x00FF; result_o[63:40]=0 even if the core returns 0xFFFF on the last beat.
- MAX_OUTSTANDING=2, core holds results for 10 cycles -> core_valid_o deasserts after 2 transfers and never exceeds 2 in flight; frame still completes correctly.
- core_ready_i toggled randomly -> core_data_o never changes while core_valid_o=1 and not accepted; beat order 0..N_BEATS-1 preserved.
- core_res_valid_i pulsed in IDLE -> err_o=1, result_o unchanged. Next start_i -> err_o=0.
- Mid-frame, beat 20 of 49: rst_i=1 for 1 cycle -> all outputs 0, IDLE. A new start_i then completes normally. Also: start_i while busy -> ignored, frame result unaffected.
